// File: rtl/rv32m_muldiv_if.sv
// Request/response handshake bundle between the core and the RV32M multiply/divide unit.
// The core is the master; the unit is the slave.
interface rv32m_muldiv_if #(
  parameter int unsigned XLEN = 32
);
  logic            req_valid;
  logic            req_ready;
  logic [2:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            resp_valid;
  logic            resp_ready;
  logic [XLEN-1:0] result;
  logic            busy;

  modport master (
    output req_valid, op, a, b, resp_ready,
    input  req_ready, resp_valid, result, busy
  );

  modport slave (
    input  req_valid, op, a, b, resp_ready,
    output req_ready, resp_valid, result, busy
  );
endinterface

// File: rtl/rv32m_muldiv.sv
// Radix-2 iterative RV32M multiply/divide unit: shift-add multiply, restoring divide,
// operating on magnitudes with a single sign fixup on the final iteration.
module rv32m_muldiv #(
  parameter int unsigned XLEN = 32
) (
  input logic           clk,
  input logic           rst,
  rv32m_muldiv_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] hi_q, lo_q, opa_q, result_q;
  logic [2:0]      op_q;
  logic            neg_q;
  logic [4:0]      cnt_q;

  logic            accept, is_div, a_signed, b_signed, a_neg, b_neg, res_neg;
  logic            div_zero, div_ovf, special;
  logic [XLEN-1:0] a_abs, b_abs, special_res;

  // Request decode
  always_comb begin
    accept   = bus.req_valid && (state_q == StIdle);
    is_div   = bus.op[2];
    a_signed = (bus.op == 3'b001) || (bus.op == 3'b010) || (bus.op == 3'b100) ||
               (bus.op == 3'b110);
    b_signed = (bus.op == 3'b001) || (bus.op == 3'b100) || (bus.op == 3'b110);
    a_neg    = a_signed && bus.a[XLEN-1];
    b_neg    = b_signed && bus.b[XLEN-1];
    a_abs    = a_neg ? ('0 - bus.a) : bus.a;
    b_abs    = b_neg ? ('0 - bus.b) : bus.b;
    // Remainder follows the dividend; everything else follows the product/quotient sign.
    res_neg  = (bus.op[2] && bus.op[1]) ? a_neg : (a_neg ^ b_neg);
    div_zero = is_div && (bus.b == '0);
    div_ovf  = is_div && !bus.op[0] && (bus.a == {1'b1, {(XLEN-1){1'b0}}}) &&
               (bus.b == '1);
    special  = div_zero || div_ovf;
    if (div_zero) begin
      special_res = bus.op[1] ? bus.a : '1;
    end else begin
      special_res = bus.op[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    end
  end

  logic [XLEN:0]     mul_sum, div_shift;
  logic [XLEN-1:0]   div_rem, hi_n, lo_n, quo_s, rem_s, final_res;
  logic              div_ok;
  logic [2*XLEN-1:0] prod, prod_s;

  // One iteration step and final sign fixup
  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opa_q} : '0);
    div_shift = {hi_q, lo_q[XLEN-1]};
    div_ok    = div_shift >= {1'b0, opa_q};
    div_rem   = div_shift[XLEN-1:0] - opa_q;
    if (op_q[2]) begin
      hi_n = div_ok ? div_rem : div_shift[XLEN-1:0];
      lo_n = {lo_q[XLEN-2:0], div_ok};
    end else begin
      hi_n = mul_sum[XLEN:1];
      lo_n = {mul_sum[0], lo_q[XLEN-1:1]};
    end
    prod   = {hi_n, lo_n};
    prod_s = neg_q ? ('0 - prod) : prod;
    quo_s  = neg_q ? ('0 - lo_n) : lo_n;
    rem_s  = neg_q ? ('0 - hi_n) : hi_n;
    unique case (op_q)
      3'b000:                 final_res = prod_s[XLEN-1:0];
      3'b001, 3'b010, 3'b011: final_res = prod_s[2*XLEN-1:XLEN];
      3'b100, 3'b101:         final_res = quo_s;
      default:                final_res = rem_s;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q     <= '0;
      lo_q     <= '0;
      opa_q    <= '0;
      result_q <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      cnt_q    <= '0;
    end else if (accept) begin
      op_q  <= bus.op;
      neg_q <= res_neg;
      cnt_q <= '0;
      if (special) begin
        result_q <= special_res;
      end else begin
        hi_q  <= '0;
        lo_q  <= is_div ? a_abs : b_abs;
        opa_q <= is_div ? b_abs : a_abs;
      end
    end else if (state_q == StCalc) begin
      hi_q  <= hi_n;
      lo_q  <= lo_n;
      cnt_q <= cnt_q + 5'd1;
      if (cnt_q == 5'd31) begin
        result_q <= final_res;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (accept) state_d = special ? StDone : StCalc;
      StCalc: if (cnt_q == 5'd31) state_d = StDone;
      StDone: if (bus.resp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.req_ready  = (state_q == StIdle);
    bus.resp_valid = (state_q == StDone);
    bus.busy       = (state_q != StIdle);
    bus.result     = result_q;
  end

endmodule

// File: tb/tb_rv32m_muldiv.sv
// Directed bench for rv32m_muldiv: expected results go into a scoreboard queue at issue
// and are popped when the unit responds.
module tb_rv32m_muldiv;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rv32m_muldiv_if bus ();

  rv32m_muldiv dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          checks = 0;
  int          fails  = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp);
    check("req_ready_at_issue", 32'(bus.req_ready), 32'd1);
    bus.op        = op;
    bus.a         = a;
    bus.b         = b;
    bus.req_valid = 1'b1;
    exp_q.push_back(exp);
    tick();
    bus.req_valid = 1'b0;
    // Operands changing after accept must not matter
    bus.op        = 3'($urandom);
    bus.a         = $urandom;
    bus.b         = $urandom;
  endtask

  task automatic await_resp(input string tag, input int exp_lat, input bit chk_busy);
    int          n       = 0;
    bit          busy_ok = 1'b1;
    logic [31:0] exp;
    while (!bus.resp_valid && n < 100) begin
      if (!bus.busy) busy_ok = 1'b0;
      tick();
      n++;
    end
    check({tag, "_resp_valid"}, 32'(bus.resp_valid), 32'd1);
    check({tag, "_latency"}, 32'(n), 32'(exp_lat));
    if (chk_busy) check({tag, "_busy"}, 32'(busy_ok && bus.busy), 32'd1);
    if (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      check({tag, "_result"}, bus.result, exp);
    end else begin
      check({tag, "_scoreboard_empty"}, 32'(exp_q.size()), 32'd1);
    end
  endtask

  task automatic release_resp(input string tag);
    bus.resp_ready = 1'b1;
    tick();
    bus.resp_ready = 1'b0;
    check({tag, "_valid_drop"}, 32'(bus.resp_valid), 32'd0);
    check({tag, "_back_idle"}, 32'(bus.req_ready), 32'd1);
  endtask

  task automatic run(input string tag, input logic [2:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] exp, input int lat);
    issue(op, a, b, exp);
    await_resp(tag, lat, 1'b1);
    release_resp(tag);
  endtask

  initial begin
    bit seen;
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b0;
    bus.op         = 3'd0;
    bus.a          = '0;
    bus.b          = '0;
    rst            = 1'b1;
    #1;
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_result", bus.result, 32'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    run("mul_neg", 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 32);
    run("mulh", 3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32);
    run("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32);
    run("mulhu", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32);
    run("div_neg", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32);
    run("rem_neg", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32);
    run("divu", 3'b101, 32'd100, 32'd7, 32'd14, 32);
    run("remu", 3'b111, 32'd100, 32'd7, 32'd2, 32);
    run("divu_by0", 3'b101, 32'h1234, 32'd0, 32'hFFFF_FFFF, 0);
    run("remu_by0", 3'b111, 32'h1234, 32'd0, 32'h1234, 0);
    run("div_by0", 3'b100, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 0);
    run("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
    run("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0);

    // Backpressure: result held, no new accept while DONE
    issue(3'b101, 32'd100, 32'd7, 32'd14);
    await_resp("divu_bp", 32, 1'b0);
    for (int i = 0; i < 5; i++) begin
      bus.req_valid = i[0];
      bus.a         = $urandom;
      bus.b         = $urandom;
      tick();
      check("bp_result_stable", bus.result, 32'd14);
      check("bp_req_ready_low", 32'(bus.req_ready), 32'd0);
      check("bp_resp_valid_held", 32'(bus.resp_valid), 32'd1);
    end
    bus.req_valid = 1'b0;
    release_resp("divu_bp");
    run("remu_after_bp", 3'b111, 32'd100, 32'd7, 32'd2, 32);

    // Asynchronous reset mid-divide aborts with no response
    bus.op        = 3'b100;
    bus.a         = 32'd1000;
    bus.b         = 32'd7;
    bus.req_valid = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    repeat (10) tick();
    #2 rst = 1'b1;
    #1;
    check("abort_req_ready", 32'(bus.req_ready), 32'd1);
    check("abort_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_result", bus.result, 32'd0);
    #1 rst = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      tick();
      if (bus.resp_valid) seen = 1'b1;
    end
    check("abort_no_resp", 32'(seen), 32'd0);
    run("mul_after_abort", 3'b000, 32'd3, 32'd5, 32'd15, 32);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
